// File: rtl/barrel_shift_left.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_left
// Description : Registered logical left barrel shifter for the CORDIC
//               datapath. Shifts the N-bit word `a` left by `shift` bits,
//               zero-filling the LSBs and discarding bits past the MSB.
//               The shift amount is one bit wider than log2(N), so a shift
//               of N or more is expressible and clears the word.
//
// Ports       : clk        - clock, all state updates on the rising edge
//               rst        - synchronous active-high reset (priority over
//                            in_valid); clears every pipeline register
//               in_valid   - a/shift qualify this cycle
//               a          - operand, N bits
//               shift      - unsigned shift amount, LOG_N+1 bits
//               o          - registered result a << shift
//               out_valid  - o holds the result of an accepted in_valid
//
// Build macro : BARREL_SHIFT_LEFT_PIPELINE_EN
//               undefined -> mux stages combinational, one output register,
//                            latency 1 cycle
//               defined   -> register after every mux stage, latency
//                            LOG_N+1 cycles; valid travels with the data
//
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_left #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N):0]   shift,
  output logic [N-1:0]         o,
  output logic                 out_valid
);

  localparam int LOG_N = $clog2(N);

  // One mux stage of the log-shifter. Stages below LOG_N shift by 2^k; the
  // top stage only ever sees shift amounts of 2^LOG_N >= N, so it clears.
  // For non-power-of-two N the lower stages alone can sum to >= N, and the
  // plain shift already empties the word in that case.
  function automatic logic [N-1:0] shift_stage(
    input logic [N-1:0] d,
    input logic         sel,
    input int           k
  );
    logic [N-1:0] r;
    r = d;
    if (sel) begin
      if (k >= LOG_N) begin
        r = '0;
      end else begin
        r = d << (1 << k);
      end
    end
    return r;
  endfunction

`ifdef BARREL_SHIFT_LEFT_PIPELINE_EN

  // Each stage registers its data, its valid bit and, for every stage but
  // the last, the shift amount still needed by the stages downstream.
  for (genvar k = 0; k <= LOG_N; k++) begin : g_stage
    logic [N-1:0] din;
    logic         vin;
    logic [LOG_N:0] sin;
    logic [N-1:0] data_d;
    logic [N-1:0] data_q;
    logic         valid_d;
    logic         valid_q;

    if (k == 0) begin : g_first
      assign din = a;
      assign vin = in_valid;
      assign sin = shift;
    end else begin : g_next
      assign din = g_stage[k-1].data_q;
      assign vin = g_stage[k-1].valid_q;
      assign sin = g_stage[k-1].g_carry.shamt_q;
    end

    // Data only moves on a valid beat so the output holds its last result
    // while in_valid is low.
    always_comb begin
      valid_d = vin;
      data_d  = data_q;
      if (vin) begin
        data_d = shift_stage(din, sin[k], k);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    if (k < LOG_N) begin : g_carry
      logic [LOG_N:0] shamt_d;
      logic [LOG_N:0] shamt_q;

      always_comb begin
        shamt_d = sin;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
        end else begin
          shamt_q <= shamt_d;
        end
      end
    end
  end

  assign o         = g_stage[LOG_N].data_q;
  assign out_valid = g_stage[LOG_N].valid_q;

`else

  // chain[k] is the word entering mux stage k; chain[LOG_N+1] is the result.
  logic [LOG_N+1:0][N-1:0] chain;
  logic [N-1:0]            o_d;
  logic [N-1:0]            o_q;
  logic                    out_valid_d;
  logic                    out_valid_q;

  assign chain[0] = a;

  for (genvar k = 0; k <= LOG_N; k++) begin : g_stage
    assign chain[k+1] = shift_stage(chain[k], shift[k], k);
  end

  always_comb begin
    o_d         = o_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      o_d = chain[LOG_N+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o         = o_q;
  assign out_valid = out_valid_q;

`endif

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_left.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift_left
// Description : Self-checking bench for barrel_shift_left. A queue-based
//               reference delays arithmetic results by the configured
//               latency; known-answer cases, back-to-back and mid-stream
//               reset cases are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_left;

  localparam int N     = 16;
  localparam int LOG_N = $clog2(N);
`ifdef BARREL_SHIFT_LEFT_PIPELINE_EN
  localparam int LAT = LOG_N + 1;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N-1:0]   a;
  logic [LOG_N:0] shift;
  logic [N-1:0]   o;
  logic           out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference pipeline: entries still in flight, oldest first.
  bit           mv_q[$];
  logic [N-1:0] md_q[$];
  logic [N-1:0] exp_o;
  logic         exp_v;

  barrel_shift_left #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .shift     (shift),
    .o         (o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // a * 2^s truncated to N bits, or zero once the shift reaches N.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int s);
    longint unsigned p;
    if (s >= N) return '0;
    p = 64'(x) * (64'd1 << s);
    return p[N-1:0];
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mv_q.delete();
    md_q.delete();
    repeat (LAT - 1) begin
      mv_q.push_back(1'b0);
      md_q.push_back('0);
    end
    exp_o = '0;
    exp_v = 1'b0;
  endtask

  // Drive one cycle (called at negedge), advance the model at the edge,
  // then compare outputs 1 time unit after the edge.
  task automatic cycle(input bit v, input logic [N-1:0] av, input int sh, input bit r);
    logic [N-1:0] d;
    in_valid = v;
    a        = av;
    shift    = sh[LOG_N:0];
    rst      = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      mv_q.push_back(v);
      md_q.push_back(ref_shift(av, sh));
      exp_v = mv_q.pop_front();
      d     = md_q.pop_front();
      if (exp_v) exp_o = d;
    end
    #1;
    check_value("o", 32'(o), 32'(exp_o));
    check_value("out_valid", 32'(out_valid), 32'(exp_v));
    @(negedge clk);
  endtask

  // Known answer: issue one operand, idle until it emerges, compare.
  task automatic kat(input logic [N-1:0] av, input int sh, input logic [N-1:0] want);
    cycle(1'b1, av, sh, 1'b0);
    repeat (LAT - 1) cycle(1'b0, av, sh, 1'b0);
    check_value("kat_o", 32'(o), 32'(want));
    check_value("kat_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    shift    = '0;
    model_reset();
    @(negedge clk);
    cycle(1'b0, '0, 0, 1'b1);
    cycle(1'b0, '0, 0, 1'b1);
    check_value("reset_o", 32'(o), 32'd0);
    check_value("reset_valid", 32'(out_valid), 32'd0);

    kat(16'hAAAA, 5'h00, 16'hAAAA);
    kat(16'hAAAA, 5'h01, 16'h5554);
    kat(16'hAAAA, 5'h02, 16'hAAA8);
    kat(16'hAAAA, 5'h0F, 16'h0000);
    kat(16'h0001, 5'h0F, 16'h8000);
    kat(16'hFFFF, 5'h10, 16'h0000);
    kat(16'hFFFF, 5'h1F, 16'h0000);
    kat(16'hFFFF, 5'h08, 16'hFF00);

    // Idle cycle: output must hold, valid must drop.
    cycle(1'b0, 16'h1234, 3, 1'b0);
    check_value("hold_o", 32'(o), 32'h0000FF00);

    // Back-to-back shifts 0,1,2 on consecutive cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hAAAA, i, 1'b0);
    repeat (LAT) cycle(1'b0, 16'h0000, 0, 1'b0);

    // Reset mid-stream drops in-flight results.
    cycle(1'b1, 16'hAAAA, 1, 1'b0);
    cycle(1'b1, 16'hAAAA, 2, 1'b0);
    cycle(1'b1, 16'hAAAA, 3, 1'b1);
    check_value("midrst_o", 32'(o), 32'd0);
    check_value("midrst_valid", 32'(out_valid), 32'd0);
    kat(16'h1234, 4, 16'h2340);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, N'($urandom),
            int'($urandom_range(0, (1 << (LOG_N + 1)) - 1)),
            $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
